// File: rtl/l2_reqs_mshr_pkg.sv
// Shared L2 MSHR types and constants.
//   STATE_INVALID   : unstable-state encoding for "no transaction"
//   STATE_INV_STALL : state that stalls an invalidating forward
//   STATE_NOSTALL   : state that lets a non-invalidating forward through
//   l2_mshr_entry_t : one request-table entry at the default widths
package l2_reqs_mshr_pkg;

  localparam int L2_TAG_BITS     = 20;
  localparam int L2_SET_BITS     = 8;
  localparam int L2_STATE_BITS   = 4;
  localparam int L2_PAYLOAD_BITS = 64;
  localparam int L2_INV_BITS     = 4;

  localparam int STATE_INVALID   = 0;
  localparam int STATE_INV_STALL = 4;
  localparam int STATE_NOSTALL   = 6;

  typedef struct packed {
    logic                       valid;
    logic [L2_TAG_BITS-1:0]     tag;
    logic [L2_SET_BITS-1:0]     set;
    logic [L2_STATE_BITS-1:0]   state;
    logic [L2_INV_BITS-1:0]     invack_cnt;
    logic [L2_PAYLOAD_BITS-1:0] payload;
  } l2_mshr_entry_t;

endpackage

// File: rtl/l2_reqs_mshr_age.sv
// Age matrix for the MSHR: older[j][k]=1 means entry j was allocated before k.
//   clk, rst          : clock, synchronous active-high reset
//   valid             : current (pre-edge) entry valid mask
//   alloc_en/idx      : entry being allocated this cycle
//   free_en/idx       : entry being released this cycle
//   oldest_valid/idx  : comb, valid entry with no valid entry older than it
module l2_mshr_age_matrix #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     valid,
  input  logic             alloc_en,
  input  logic [IDX_W-1:0] alloc_idx,
  input  logic             free_en,
  input  logic [IDX_W-1:0] free_idx,
  output logic             oldest_valid,
  output logic [IDX_W-1:0] oldest_idx
);

  logic [N-1:0][N-1:0] older;

  // New entry is younger than everything live and older than nothing.
  // A freed row is cleared so a stale entry never shadows a live one;
  // its column is rewritten on its next allocation.
  always_ff @(posedge clk) begin
    if (rst) begin
      older <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          if (alloc_en && alloc_idx == IDX_W'(k))
            older[j][k] <= valid[j] && (j != k);
          if (alloc_en && alloc_idx == IDX_W'(j))
            older[j][k] <= 1'b0;
          if (free_en && free_idx == IDX_W'(j))
            older[j][k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    oldest_valid = |valid;
    oldest_idx   = '0;
    for (int i = N-1; i >= 0; i--) begin
      logic has_older;
      has_older = 1'b0;
      for (int j = 0; j < N; j++)
        has_older = has_older | (valid[j] & older[j][i]);
      if (valid[i] && !has_older)
        oldest_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/l2_reqs_mshr.sv
// N-entry L2 miss/request buffer between the L2 request FSM and the
// coherence forward/response paths.
//   alloc_*   : allocate lowest free entry (alloc_ready = !full)
//   upd_*     : state/payload update of a live entry
//   inv_*     : per-entry invack counter load/decrement, inv_zero status
//   free_*    : release an entry
//   lkp_*     : registered tag/set lookup with forward-stall decision
//   oldest_*  : comb, earliest-allocated live entry
//   count     : registered occupancy
//   entry_*   : flattened per-entry state/payload
module l2_reqs_mshr
  import l2_reqs_mshr_pkg::*;
#(
  parameter int N_REQS          = 4,
  parameter int TAG_BITS        = L2_TAG_BITS,
  parameter int SET_BITS        = L2_SET_BITS,
  parameter int STATE_BITS      = L2_STATE_BITS,
  parameter int PAYLOAD_BITS    = L2_PAYLOAD_BITS,
  parameter int INV_BITS        = L2_INV_BITS,
  parameter int INV_STALL_STATE = STATE_INV_STALL,
  parameter int NOSTALL_STATE   = STATE_NOSTALL,
  localparam int IDX_W = $clog2(N_REQS),
  localparam int CNT_W = $clog2(N_REQS+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [TAG_BITS-1:0]            alloc_tag,
  input  logic [SET_BITS-1:0]            alloc_set,
  input  logic [STATE_BITS-1:0]          alloc_state,
  input  logic [PAYLOAD_BITS-1:0]        alloc_payload,
  output logic [IDX_W-1:0]               alloc_idx,
  output logic                           alloc_set_conflict,
  input  logic                           upd_valid,
  input  logic [IDX_W-1:0]               upd_idx,
  input  logic [STATE_BITS-1:0]          upd_state,
  input  logic                           upd_payload_en,
  input  logic [PAYLOAD_BITS-1:0]        upd_payload,
  input  logic                           inv_load,
  input  logic                           inv_dec,
  input  logic [IDX_W-1:0]               inv_idx,
  input  logic [INV_BITS-1:0]            inv_val,
  output logic [N_REQS-1:0]              inv_zero,
  input  logic                           free_valid,
  input  logic [IDX_W-1:0]               free_idx,
  input  logic                           lkp_valid,
  input  logic [TAG_BITS-1:0]            lkp_tag,
  input  logic [SET_BITS-1:0]            lkp_set,
  input  logic                           lkp_is_inv,
  output logic                           lkp_hit,
  output logic [IDX_W-1:0]               lkp_idx,
  output logic                           lkp_stall,
  output logic                           oldest_valid,
  output logic [IDX_W-1:0]               oldest_idx,
  output logic [CNT_W-1:0]               count,
  output logic [N_REQS*STATE_BITS-1:0]   entry_state,
  output logic [N_REQS*PAYLOAD_BITS-1:0] entry_payload
);

  // Same layout as l2_mshr_entry_t, but tracking parameter overrides.
  typedef struct packed {
    logic                    valid;
    logic [TAG_BITS-1:0]     tag;
    logic [SET_BITS-1:0]     set;
    logic [STATE_BITS-1:0]   state;
    logic [INV_BITS-1:0]     invack_cnt;
    logic [PAYLOAD_BITS-1:0] payload;
  } entry_t;

  entry_t ent [N_REQS];

  logic [N_REQS-1:0] vld;
  logic              alloc_fire;
  logic              free_eff;
  logic              hit_c;
  logic [IDX_W-1:0]  hit_idx_c;
  logic [STATE_BITS-1:0] hit_state_c;

  always_comb begin
    for (int i = 0; i < N_REQS; i++) vld[i] = ent[i].valid;
  end

  assign alloc_ready = ~&vld;
  assign alloc_fire  = alloc_valid && alloc_ready;

  // Decisions below all use pre-edge contents, so a same-cycle free never
  // frees up the slot that alloc_idx points at.
  always_comb begin
    alloc_idx          = '0;
    alloc_set_conflict = 1'b0;
    free_eff           = 1'b0;
    inv_zero           = '0;
    entry_state        = '0;
    entry_payload      = '0;
    for (int i = N_REQS-1; i >= 0; i--) begin
      if (!vld[i]) alloc_idx = IDX_W'(i);
      if (vld[i] && ent[i].set == alloc_set) alloc_set_conflict = 1'b1;
      if (vld[i] && free_valid && free_idx == IDX_W'(i)) free_eff = 1'b1;
      inv_zero[i] = vld[i] && (ent[i].invack_cnt == '0);
      entry_state[i*STATE_BITS +: STATE_BITS] =
        vld[i] ? ent[i].state : STATE_BITS'(STATE_INVALID);
      entry_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS] = ent[i].payload;
    end
  end

  // Ascending scan: the highest matching index wins.
  always_comb begin
    hit_c       = 1'b0;
    hit_idx_c   = '0;
    hit_state_c = '0;
    for (int i = 0; i < N_REQS; i++) begin
      if (vld[i] && ent[i].tag == lkp_tag && ent[i].set == lkp_set) begin
        hit_c       = 1'b1;
        hit_idx_c   = IDX_W'(i);
        hit_state_c = ent[i].state;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQS; i++) ent[i] <= '0;
      count     <= '0;
      lkp_hit   <= 1'b0;
      lkp_idx   <= '0;
      lkp_stall <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQS; i++) begin
        if (ent[i].valid) begin
          if (free_valid && free_idx == IDX_W'(i)) begin
            ent[i].valid <= 1'b0;
          end else begin
            if (upd_valid && upd_idx == IDX_W'(i)) begin
              ent[i].state <= upd_state;
              if (upd_payload_en) ent[i].payload <= upd_payload;
            end
            if (inv_idx == IDX_W'(i)) begin
              if (inv_load)
                ent[i].invack_cnt <= inv_val;
              else if (inv_dec && ent[i].invack_cnt != '0)
                ent[i].invack_cnt <= ent[i].invack_cnt - INV_BITS'(1);
            end
          end
        end else if (alloc_fire && alloc_idx == IDX_W'(i)) begin
          ent[i] <= '{valid: 1'b1, tag: alloc_tag, set: alloc_set,
                      state: alloc_state, invack_cnt: '1,
                      payload: alloc_payload};
        end
      end

      case ({alloc_fire, free_eff})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (lkp_valid) begin
        lkp_hit   <= hit_c;
        lkp_idx   <= hit_idx_c;
        lkp_stall <= hit_c && (lkp_is_inv ?
                       (hit_state_c == STATE_BITS'(INV_STALL_STATE)) :
                       (hit_state_c != STATE_BITS'(NOSTALL_STATE)));
      end
    end
  end

  l2_mshr_age_matrix #(.N(N_REQS)) u_age (
    .clk          (clk),
    .rst          (rst),
    .valid        (vld),
    .alloc_en     (alloc_fire),
    .alloc_idx    (alloc_idx),
    .free_en      (free_eff),
    .free_idx     (free_idx),
    .oldest_valid (oldest_valid),
    .oldest_idx   (oldest_idx)
  );

endmodule

// File: tb/tb_l2_reqs_mshr.sv
// Directed bench for l2_reqs_mshr at default parameters (N_REQS=4).
module tb_l2_reqs_mshr;

  localparam int N  = 4;
  localparam int SB = 4;
  localparam int PB = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready;
  logic [19:0]   alloc_tag;
  logic [7:0]    alloc_set;
  logic [3:0]    alloc_state;
  logic [63:0]   alloc_payload;
  logic [1:0]    alloc_idx;
  logic          alloc_set_conflict;
  logic          upd_valid;
  logic [1:0]    upd_idx;
  logic [3:0]    upd_state;
  logic          upd_payload_en;
  logic [63:0]   upd_payload;
  logic          inv_load, inv_dec;
  logic [1:0]    inv_idx;
  logic [3:0]    inv_val;
  logic [3:0]    inv_zero;
  logic          free_valid;
  logic [1:0]    free_idx;
  logic          lkp_valid;
  logic [19:0]   lkp_tag;
  logic [7:0]    lkp_set;
  logic          lkp_is_inv;
  logic          lkp_hit;
  logic [1:0]    lkp_idx;
  logic          lkp_stall;
  logic          oldest_valid;
  logic [1:0]    oldest_idx;
  logic [2:0]    count;
  logic [N*SB-1:0] entry_state;
  logic [N*PB-1:0] entry_payload;

  int n_chk = 0;
  int n_bad = 0;

  l2_reqs_mshr dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_tag(alloc_tag), .alloc_set(alloc_set), .alloc_state(alloc_state),
    .alloc_payload(alloc_payload), .alloc_idx(alloc_idx),
    .alloc_set_conflict(alloc_set_conflict),
    .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_state(upd_state),
    .upd_payload_en(upd_payload_en), .upd_payload(upd_payload),
    .inv_load(inv_load), .inv_dec(inv_dec), .inv_idx(inv_idx),
    .inv_val(inv_val), .inv_zero(inv_zero),
    .free_valid(free_valid), .free_idx(free_idx),
    .lkp_valid(lkp_valid), .lkp_tag(lkp_tag), .lkp_set(lkp_set),
    .lkp_is_inv(lkp_is_inv), .lkp_hit(lkp_hit), .lkp_idx(lkp_idx),
    .lkp_stall(lkp_stall),
    .oldest_valid(oldest_valid), .oldest_idx(oldest_idx),
    .count(count), .entry_state(entry_state), .entry_payload(entry_payload)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0; upd_valid = 0; upd_payload_en = 0;
    inv_load = 0; inv_dec = 0; free_valid = 0; lkp_valid = 0;
  endtask

  task automatic do_alloc(input logic [19:0] t, input logic [7:0] s,
                          input logic [3:0] st, input logic [63:0] p);
    alloc_valid = 1; alloc_tag = t; alloc_set = s;
    alloc_state = st; alloc_payload = p;
    tick();
    alloc_valid = 0;
  endtask

  task automatic do_free(input logic [1:0] i);
    free_valid = 1; free_idx = i;
    tick();
    free_valid = 0;
  endtask

  task automatic do_upd(input logic [1:0] i, input logic [3:0] st,
                        input logic pe, input logic [63:0] p);
    upd_valid = 1; upd_idx = i; upd_state = st;
    upd_payload_en = pe; upd_payload = p;
    tick();
    upd_valid = 0; upd_payload_en = 0;
  endtask

  task automatic do_inv(input logic ld, input logic dc, input logic [3:0] v);
    inv_load = ld; inv_dec = dc; inv_idx = 2'd0; inv_val = v;
    tick();
    inv_load = 0; inv_dec = 0;
  endtask

  task automatic do_lkp(input logic [19:0] t, input logic [7:0] s,
                        input logic inv);
    lkp_valid = 1; lkp_tag = t; lkp_set = s; lkp_is_inv = inv;
    tick();
    lkp_valid = 0;
  endtask

  task automatic chk_reset();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_oldest_valid", 64'(oldest_valid), 64'd0);
    chk("rst_oldest_idx", 64'(oldest_idx), 64'd0);
    chk("rst_inv_zero", 64'(inv_zero), 64'd0);
    chk("rst_lkp_hit", 64'(lkp_hit), 64'd0);
    chk("rst_lkp_idx", 64'(lkp_idx), 64'd0);
    chk("rst_lkp_stall", 64'(lkp_stall), 64'd0);
    chk("rst_entry_state", 64'(entry_state), 64'd0);
    chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
  endtask

  initial begin
    idle();
    alloc_tag = '0; alloc_set = '0; alloc_state = '0; alloc_payload = '0;
    upd_idx = '0; upd_state = '0; upd_payload = '0;
    inv_idx = '0; inv_val = '0; free_idx = '0;
    lkp_tag = '0; lkp_set = '0; lkp_is_inv = 0;
    rst = 1;
    tick();
    rst = 0;
    chk_reset();

    // fill: entry i tag 0x100+i set 0x10+i, entry 3 is tag 0xABC set 0x30 state 4
    for (int i = 0; i < 3; i++) begin
      chk("fill_alloc_idx", 64'(alloc_idx), 64'(i));
      do_alloc(20'h100 + 20'(i), 8'h10 + 8'(i), 4'd1, 64'(i));
    end
    chk("fill_alloc_idx3", 64'(alloc_idx), 64'd3);
    do_alloc(20'hABC, 8'h30, 4'd4, 64'h3);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    chk("full_oldest", 64'(oldest_idx), 64'd0);
    chk("full_state3", 64'(entry_state[3*SB +: SB]), 64'd4);
    chk("full_payload2", entry_payload[2*PB +: PB], 64'd2);

    do_alloc(20'h777, 8'h77, 4'd7, 64'h77);
    chk("over_count", 64'(count), 64'd4);
    chk("over_state3", 64'(entry_state[3*SB +: SB]), 64'd4);

    // free 1, refill 1, free 0 -> oldest moves to 2
    do_free(2'd1);
    chk("free1_count", 64'(count), 64'd3);
    chk("free1_alloc_idx", 64'(alloc_idx), 64'd1);
    do_alloc(20'h200, 8'h20, 4'd2, 64'h55);
    chk("realloc1_count", 64'(count), 64'd4);
    chk("realloc1_oldest", 64'(oldest_idx), 64'd0);
    do_free(2'd0);
    chk("free0_oldest", 64'(oldest_idx), 64'd2);
    chk("free0_count", 64'(count), 64'd3);

    alloc_set = 8'h12; #1;
    chk("conflict_12", 64'(alloc_set_conflict), 64'd1);
    alloc_set = 8'h13; #1;
    chk("conflict_13", 64'(alloc_set_conflict), 64'd0);
    alloc_set = 8'h10; #1;
    chk("conflict_freed", 64'(alloc_set_conflict), 64'd0);

    // invack counter on entry 0
    chk("re0_alloc_idx", 64'(alloc_idx), 64'd0);
    do_alloc(20'h300, 8'h40, 4'd3, 64'h0);
    chk("re0_inv_zero", 64'(inv_zero), 64'd0);
    do_inv(1, 0, 4'd2);
    chk("inv_ld2", 64'(inv_zero), 64'd0);
    do_inv(0, 1, 4'd0);
    chk("inv_dec1", 64'(inv_zero), 64'd0);
    do_inv(0, 1, 4'd0);
    chk("inv_dec2", 64'(inv_zero), 64'd1);
    do_inv(0, 1, 4'd0);
    chk("inv_dec_sat", 64'(inv_zero), 64'd1);
    do_inv(1, 1, 4'd5);
    chk("inv_ld_wins", 64'(inv_zero), 64'd0);
    for (int i = 0; i < 4; i++) do_inv(0, 1, 4'd0);
    chk("inv_5_dec4", 64'(inv_zero), 64'd0);
    do_inv(0, 1, 4'd0);
    chk("inv_5_dec5", 64'(inv_zero), 64'd1);

    // lookups
    do_lkp(20'hABC, 8'h30, 1);
    chk("lkp_hit3", 64'(lkp_hit), 64'd1);
    chk("lkp_idx3", 64'(lkp_idx), 64'd3);
    chk("lkp_stall_inv4", 64'(lkp_stall), 64'd1);
    lkp_tag = 20'h999; tick();
    chk("lkp_hold_hit", 64'(lkp_hit), 64'd1);
    chk("lkp_hold_idx", 64'(lkp_idx), 64'd3);
    do_upd(2'd3, 4'd6, 0, 64'h0);
    chk("upd_state3", 64'(entry_state[3*SB +: SB]), 64'd6);
    do_lkp(20'hABC, 8'h30, 0);
    chk("lkp_nostall_hit", 64'(lkp_hit), 64'd1);
    chk("lkp_nostall", 64'(lkp_stall), 64'd0);
    do_lkp(20'hABC, 8'h30, 1);
    chk("lkp_inv_state6", 64'(lkp_stall), 64'd0);
    do_lkp(20'hABD, 8'h30, 1);
    chk("lkp_miss_hit", 64'(lkp_hit), 64'd0);
    chk("lkp_miss_stall", 64'(lkp_stall), 64'd0);
    do_lkp(20'h102, 8'h12, 0);
    chk("lkp_e2_idx", 64'(lkp_idx), 64'd2);
    chk("lkp_e2_stall", 64'(lkp_stall), 64'd1);

    // updates
    do_upd(2'd2, 4'd5, 1, 64'hDEAD_BEEF);
    chk("upd_payload2", entry_payload[2*PB +: PB], 64'hDEAD_BEEF);
    chk("upd_state2", 64'(entry_state[2*SB +: SB]), 64'd5);
    do_upd(2'd2, 4'd0, 0, 64'h0);
    chk("upd0_count", 64'(count), 64'd4);
    chk("upd0_ready", 64'(alloc_ready), 64'd0);
    chk("upd0_payload2", entry_payload[2*PB +: PB], 64'hDEAD_BEEF);

    // double free
    do_free(2'd1);
    chk("dfree_a", 64'(count), 64'd3);
    do_free(2'd1);
    chk("dfree_b", 64'(count), 64'd3);

    // alloc + free of a different entry together
    chk("af_alloc_idx", 64'(alloc_idx), 64'd1);
    free_valid = 1; free_idx = 2'd2;
    do_alloc(20'h400, 8'h50, 4'd2, 64'h44);
    free_valid = 0;
    chk("af_count", 64'(count), 64'd3);
    chk("af_alloc_idx_next", 64'(alloc_idx), 64'd2);
    chk("af_state1", 64'(entry_state[1*SB +: SB]), 64'd2);

    // free beats update on the same entry
    free_valid = 1; free_idx = 2'd3;
    do_upd(2'd3, 4'd9, 0, 64'h0);
    free_valid = 0;
    chk("fu_count", 64'(count), 64'd2);
    chk("fu_state3", 64'(entry_state[3*SB +: SB]), 64'd0);

    // reset mid-sequence, with a competing alloc strobe
    rst = 1;
    alloc_valid = 1;
    tick();
    rst = 0;
    alloc_valid = 0;
    chk_reset();

    // multiple hits: highest index wins
    do_alloc(20'h5, 8'h5, 4'd1, 64'h0);
    do_alloc(20'h5, 8'h5, 4'd1, 64'h0);
    do_lkp(20'h5, 8'h5, 0);
    chk("multi_hit", 64'(lkp_hit), 64'd1);
    chk("multi_idx", 64'(lkp_idx), 64'd1);
    chk("multi_stall", 64'(lkp_stall), 64'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_reqs_mshr.md
Name: l2_reqs_mshr

Overview:
- Parametrised N-entry L2 miss/request buffer (MSHR) sitting between the L2 request FSM and the coherence forward/response paths.
- Generalises the fixed request table:
  - explicit alloc/free handshake with occupancy tracking and full/empty status;
  - per-entry invack counters with decrement and zero detection;
  - registered address lookup with forward-stall evaluation;
  - age tracking that reports the oldest live entry.

Parameters:
N_REQS, 4, number of entries (>=2)
TAG_BITS, 20, tag width
SET_BITS, 8, set index width
STATE_BITS, 4, unstable-state encoding width; value 0 = INVALID
PAYLOAD_BITS, 64, opaque per-entry data (cpu_msg, hsize, hprot, way, offsets, word)
INV_BITS, 4, invack counter width
INV_STALL_STATE, 4, state that stalls an invalidating forward
NOSTALL_STATE, 6, state that does not stall a non-invalidating forward
(localparams: IDX_W = $clog2(N_REQS), CNT_W = $clog2(N_REQS+1))

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
alloc_valid  in  1  allocation request
alloc_ready  out  1  = !full
alloc_tag  in  TAG_BITS  tag of new entry
alloc_set  in  SET_BITS  set of new entry
alloc_state  in  STATE_BITS  initial state (must be non-zero)
alloc_payload  in  PAYLOAD_BITS  initial payload
alloc_idx  out  IDX_W  lowest-index free entry (combinational, valid when alloc_ready)
alloc_set_conflict  out  1  comb: some valid entry has set == alloc_set
upd_valid  in  1  state/payload update strobe
upd_idx  in  IDX_W  entry to update
upd_state  in  STATE_BITS  new state
upd_payload_en  in  1  also write payload
upd_payload  in  PAYLOAD_BITS  new payload
inv_load  in  1  load invack counter
inv_dec  in  1  decrement invack counter
inv_idx  in  IDX_W  entry for inv_load/inv_dec
inv_val  in  INV_BITS  load value
inv_zero  out  N_REQS  bit i = valid[i] && invack_cnt[i]==0
free_valid  in  1  release entry
free_idx  in  IDX_W  entry to release
lkp_valid  in  1  lookup strobe
lkp_tag  in  TAG_BITS  lookup tag
lkp_set  in  SET_BITS  lookup set
lkp_is_inv  in  1  forward is an invalidation
lkp_hit  out  1  registered hit
lkp_idx  out  IDX_W  registered hit index
lkp_stall  out  1  registered forward-stall decision
oldest_valid  out  1  comb: at least one valid entry
oldest_idx  out  IDX_W  comb: valid entry allocated earliest
count  out  CNT_W  registered occupancy
entry_state  out  N_REQS*STATE_BITS  flattened states (INVALID when not valid)
entry_payload  out  N_REQS*PAYLOAD_BITS  flattened payloads

Behaviour:
- Reset (rst high at posedge):
  - all valid=0, count=0, age matrix cleared;
  - lkp_hit=0, lkp_idx=0, lkp_stall=0;
  - alloc_ready=1, oldest_valid=0, oldest_idx=0, inv_zero=0;
  - rst overrides every same-cycle strobe.
- Alloc:
  - fires on alloc_valid && alloc_ready.
  - Writes entry alloc_idx: valid=1, tag, set, state, payload, invack_cnt = all-ones (max).
  - alloc_valid while full is ignored; no state change.
- Update (upd_valid):
  - writes state (and payload if upd_payload_en) of upd_idx.
  - Ignored if that entry is not valid.
  - Writing state 0 does NOT free the entry; only free_valid frees.
- Invack counter:
  - inv_load writes inv_val.
  - inv_dec decrements, saturating at 0.
  - Both asserted: load wins.
  - Ignored on an invalid entry.
- Free: free_valid clears valid[free_idx]; a free of an already-invalid entry is ignored (count unchanged).
- Same-entry priority, same cycle: free > update and inv ops.
- Alloc never targets the entry freed in the same cycle; that entry is still valid at evaluation time.
- count: +1 on a fired alloc, -1 on an effective free; both in the same cycle leave it unchanged. Must never exceed N_REQS or underflow.
- Age matrix:
  - on alloc of entry k, set older[j][k]=1 for every valid j, and clear older[k][*].
  - oldest_idx = the valid entry with no valid entry older than it.
- Lookup:
  - 1-cycle latency; compares pre-edge contents, so it does not see a same-cycle alloc, update or free.
  - Hit = valid && tag and set match. Multiple hits: highest index wins.
  - lkp_stall = hit && (lkp_is_inv ? state==INV_STALL_STATE : state!=NOSTALL_STATE).
  - lkp_* registers update only when lkp_valid; otherwise they hold.
- All combinational outputs depend only on registered state plus the alloc_set input.

Decomposition:
- Shared package (spandex types/consts): STATE_INVALID encoding; the state constants used as INV_STALL_STATE/NOSTALL_STATE defaults; an l2_mshr_entry_t struct {valid, tag, set, state, invack_cnt, payload}.
- One sub-module: l2_mshr_age_matrix (N×N age bits, alloc/free inputs, oldest_idx/oldest_valid outputs).

Test Plan:
- Reset, then 4 allocs with N_REQS=4 -> alloc_idx 0,1,2,3; count 4; alloc_ready 0; a fifth alloc is ignored and count stays 4.
- Free entry 1, then alloc -> alloc_idx=1; oldest_idx=0; free 0 -> oldest_idx=2 (1 is now youngest).
- Alloc set=0x12 with entry 2 valid at set 0x12 -> alloc_set_conflict=1; set 0x13 -> 0.
- inv_load 2 on entry 0, then inv_dec ×3 -> counter sequence 2,1,0,0; inv_zero[0]=1 after the second dec; inv_load+inv_dec same cycle with value 5 -> 5.
- Entry 3 tag 0xABC state 4; lookup with lkp_is_inv=1 -> next cycle lkp_hit=1, lkp_idx=3, lkp_stall=1. Change state to 6 and look up with lkp_is_inv=0 -> lkp_stall=0.
- Alloc + free of a different entry in the same cycle -> count unchanged. Assert rst mid-sequence -> all outputs return to reset values next cycle.
